uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: P_Data  in  8  byte to send; Data_Valid  in  1  one-cycle send request.
REQ-004 SHALL have ports: PAR_EN  in  1  parity bit enable; PAR_TYP  in  1  0=even, 1=odd.
REQ-005 SHALL have ports: ser_done  in  1  serializer last-bit flag; ser_data  in  1  serializer bit.
REQ-006 SHALL have ports: ser_en  out  1  serializer enable; ser_pdata  out  8  latched byte to serializer.
REQ-007 SHALL have ports: TX_OUT  out  1  line output, idle high; busy  out  1  frame in progress; frame_err  out  1  serializer timeout sticky flag.

Function
REQ-008 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-009 SHALL accept Data_Valid only in IDLE or STOP; on accept latch P_Data, PAR_EN, PAR_TYP and the computed parity bit, then go to START next cycle.
REQ-010 SHALL ignore Data_Valid in START, DATA and PARITY; latched config SHALL NOT change mid-frame.
REQ-011 SHALL hold START exactly one cycle, TX_OUT=0, ser_en=1, then go to DATA.
REQ-012 SHALL drive ser_en = 1 in START, and in DATA while ser_done=0; ser_en = 0 in all other cases.
REQ-013 SHALL drive TX_OUT = ser_data in DATA; bit 0 first (appears first DATA cycle), bit 7 on the cycle ser_done=1.
REQ-014 SHALL leave DATA on the cycle ser_done=1: to PARITY if latched PAR_EN=1, else to STOP.
REQ-015 SHALL hold PARITY one cycle with TX_OUT = parity bit: even = XOR of 8 data bits; odd = its inverse.
REQ-016 SHALL hold STOP one cycle, TX_OUT=1; with no Data_Valid go to IDLE, with Data_Valid go to START (back-to-back, no idle gap).
REQ-017 SHALL drive TX_OUT=1 in IDLE; TX_OUT SHALL be decoded from the registered state only, with no other logic.
REQ-018 SHALL drive busy = 1 in every state except IDLE.
REQ-019 SHALL count DATA cycles; if ser_done is not seen by the 9th DATA cycle, SHALL go to STOP and set frame_err.
REQ-020 frame_err SHALL stay set until reset or the next accepted Data_Valid, which clears it.
REQ-021 Frame length SHALL be 10 cycles without parity and 11 with parity, measured from START to the end of STOP.

Reset
REQ-022 rst=1 SHALL force IDLE asynchronously, independent of clk.
REQ-023 Reset values: TX_OUT=1, busy=0, ser_en=0, frame_err=0, ser_pdata=0x00, parity=0, DATA counter=0.
REQ-024 Reset mid-frame SHALL abort the frame immediately, with no stop bit emitted; first accept allowed on first edge after rst falls.

Structure
REQ-025 Shared package uart_pkg SHALL hold: state enum (IDLE, START, DATA, PARITY, STOP); PAR_EVEN=0 / PAR_ODD=1; DATA_W=8; SER_TIMEOUT=9.
REQ-026 Parity computation SHALL be one sub-module uart_parity_calc (inputs data, type; output par_bit), instantiated once.
REQ-027 FSM, DATA counter and output decode SHALL live in uart_tx_ctrl; the serializer stays external.

Verification
REQ-028 P_Data=0xA5, PAR_EN=0, one Data_Valid pulse -> TX_OUT = 0, 1,0,1,0,0,1,0,1, 1 (10 cycles); busy high 10 cycles.
REQ-029 P_Data=0x07, PAR_EN=1, PAR_TYP=0 -> parity cycle TX_OUT=1; with PAR_TYP=1 -> 0; frame is 11 cycles.
REQ-030 0x55 then 0x0F, second Data_Valid in the STOP cycle -> START directly after STOP; busy never drops.
REQ-031 Data_Valid pulsed during DATA with P_Data=0xFF -> ignored; the frame in progress is unchanged; FSM returns to IDLE after STOP.
REQ-032 Serializer model never asserts ser_done -> after 9 DATA cycles FSM goes to STOP, frame_err=1; next accept clears it.
REQ-033 rst pulsed in the 4th DATA cycle -> TX_OUT=1, busy=0, ser_en=0 without waiting for a clk edge; next frame is clean.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit controller: FSM encoding, parity
// selection constants, datapath width and serializer timeout.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SER_TIMEOUT = 9;
  localparam int unsigned CNT_W       = 4;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic par_type);
    return (^data) ^ (par_type == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator for one UART data byte; even or odd selected by par_type_i.
module uart_parity_calc
  import uart_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic              par_type_i,
  output logic              par_bit_o
);

  assign par_bit_o = calc_parity(data_i, par_type_i);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and stop
// bits around an external serializer, with a serializer timeout guard.
module uart_tx_ctrl
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] P_Data,
  input  logic              Data_Valid,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              ser_done,
  input  logic              ser_data,
  output logic              ser_en,
  output logic [DATA_W-1:0] ser_pdata,
  output logic              TX_OUT,
  output logic              busy,
  output logic              frame_err
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic               par_q, par_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_err_q, frame_err_d;
  logic               accept;

  assign accept = Data_Valid && ((state_q == IDLE) || (state_q == STOP));

  // Config only moves on an accepted request, so it is frozen for the whole frame.
  always_comb begin
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    if (accept) begin
      data_d    = P_Data;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
    end
  end

  // Fed from the next-state config so the latched parity always matches the latched byte.
  uart_parity_calc u_parity (
    .data_i     (data_d),
    .par_type_i (par_typ_d),
    .par_bit_o  (par_d)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    frame_err_d = frame_err_q;
    if (accept) begin
      frame_err_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: state_d = DATA;
      DATA: begin
        if (ser_done) begin
          state_d = par_en_q ? PARITY : STOP;
        end else if (cnt_q == CNT_W'(SER_TIMEOUT - 1)) begin
          state_d     = STOP;
          frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= PAR_EVEN;
      par_q       <= 1'b0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    TX_OUT = 1'b1;
    ser_en = 1'b0;
    unique case (state_q)
      IDLE:   TX_OUT = 1'b1;
      START: begin
        TX_OUT = 1'b0;
        ser_en = 1'b1;
      end
      DATA: begin
        TX_OUT = ser_data;
        ser_en = ~ser_done;
      end
      PARITY: TX_OUT = par_q;
      STOP:   TX_OUT = 1'b1;
      default: TX_OUT = 1'b1;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign ser_pdata = data_q;
  assign frame_err = frame_err_q;

endmodule
